// File: rtl/axi_master_arbiter_if.sv
// Bundle of requester-side and master-side signals around the command arbiter.
// The "master" modport is the arbiter's view: it is the single command
// master towards the AXI engine. The "slave" modport is the surrounding
// environment, which contains the requesters and the AXI engine.
interface axi_master_arbiter_if #(
  parameter int NUM_REQ = 4
);

  // Requester side
  logic [NUM_REQ-1:0]    i_req;
  logic [2*NUM_REQ-1:0]  i_req_rw;
  logic [3*NUM_REQ-1:0]  i_req_size;
  logic [32*NUM_REQ-1:0] i_req_addr;
  logic [64*NUM_REQ-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]    o_gnt;
  logic [NUM_REQ-1:0]    o_resp_valid;
  logic [63:0]           o_resp_rdata;
  logic                  o_resp_error;
  logic                  o_resp_invalid;
  logic                  o_busy;

  // AXI master engine side
  logic [1:0]            o_cmd_rw;
  logic [2:0]            o_cmd_size;
  logic [31:0]           o_cmd_addr;
  logic [63:0]           o_cmd_wdata;
  logic                  o_cmd_clear;
  logic                  i_cmd_wait;
  logic                  i_cmd_done;
  logic                  i_cmd_error;
  logic                  i_cmd_invalid;
  logic [63:0]           i_cmd_rdata;

  modport master (
    input  i_req, i_req_rw, i_req_size, i_req_addr, i_req_wdata,
    output o_gnt, o_resp_valid, o_resp_rdata, o_resp_error, o_resp_invalid, o_busy,
    output o_cmd_rw, o_cmd_size, o_cmd_addr, o_cmd_wdata, o_cmd_clear,
    input  i_cmd_wait, i_cmd_done, i_cmd_error, i_cmd_invalid, i_cmd_rdata
  );

  modport slave (
    output i_req, i_req_rw, i_req_size, i_req_addr, i_req_wdata,
    input  o_gnt, o_resp_valid, o_resp_rdata, o_resp_error, o_resp_invalid, o_busy,
    input  o_cmd_rw, o_cmd_size, o_cmd_addr, o_cmd_wdata, o_cmd_clear,
    output i_cmd_wait, i_cmd_done, i_cmd_error, i_cmd_invalid, i_cmd_rdata
  );

endinterface

// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter sharing one simple AXI master command port between
// NUM_REQ requesters. One transaction is outstanding at a time: issue, wait
// for completion, then hand the latched result back to the owner.
module axi_master_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  axi_master_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arbState_e;

  arbState_e          state_q, state_d;
  logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]   grantIdx_q, grantIdx_d;
  logic               isRead_q, isRead_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               error_q, error_d;
  logic               invalid_q, invalid_d;

  logic [NUM_REQ-1:0] eligible;
  logic               selValid;
  logic [IDX_W-1:0]   selIdx;
  logic [IDX_W-1:0]   nextPtr;

  logic [1:0]         grantRw;
  logic [2:0]         grantSize;
  logic [31:0]        grantAddr;
  logic [63:0]        grantWdata;
  logic               issueReserved;
  logic               issueStall;
  logic               issueGo;

  // Live fields of the currently granted requester and the ISSUE decision.
  assign grantRw       = bus.i_req_rw[2*grantIdx_q +: 2];
  assign grantSize     = bus.i_req_size[3*grantIdx_q +: 3];
  assign grantAddr     = bus.i_req_addr[32*grantIdx_q +: 32];
  assign grantWdata    = bus.i_req_wdata[64*grantIdx_q +: 64];
  assign issueReserved = (state_q == ARB_ISSUE) && (grantRw == 2'b11);
  assign issueStall    = (state_q == ARB_ISSUE) && !issueReserved && bus.i_cmd_wait;
  assign issueGo       = (state_q == ARB_ISSUE) && !issueReserved && !bus.i_cmd_wait;
  assign nextPtr       = (grantIdx_q == IDX_W'(NUM_REQ-1)) ? '0 : grantIdx_q + 1'b1;

  // A requester competes only while requesting with a non-zero command.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = bus.i_req[k] && (bus.i_req_rw[2*k +: 2] != 2'b00);
    end
  end

  // Pick the first eligible requester starting at the round-robin pointer.
  always_comb begin
    int cand;
    selValid = 1'b0;
    selIdx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rrPtr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!selValid && eligible[cand]) begin
        selValid = 1'b1;
        selIdx   = IDX_W'(cand);
      end
    end
  end

  // State and bookkeeping registers; reset abandons any transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ARB_IDLE;
      rrPtr_q    <= '0;
      grantIdx_q <= '0;
      isRead_q   <= 1'b0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      grantIdx_q <= grantIdx_d;
      isRead_q   <= isRead_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
      invalid_q  <= invalid_d;
    end
  end

  // Next-state logic, including pointer advance and result capture.
  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    grantIdx_d = grantIdx_q;
    isRead_d   = isRead_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    invalid_d  = invalid_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (selValid) begin
          grantIdx_d = selIdx;
          state_d    = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (issueReserved) begin
          rrPtr_d   = nextPtr;
          rdata_d   = '0;
          error_d   = 1'b1;
          invalid_d = 1'b1;
          state_d   = ARB_RESP;
        end else if (issueGo) begin
          rrPtr_d  = nextPtr;
          isRead_d = (grantRw == 2'b10);
          if (bus.i_cmd_done) begin
            rdata_d   = '0;
            error_d   = bus.i_cmd_error;
            invalid_d = bus.i_cmd_invalid;
            state_d   = ARB_RESP;
          end else begin
            state_d = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (bus.i_cmd_done && !bus.i_cmd_wait) begin
          rdata_d   = isRead_q ? bus.i_cmd_rdata : 64'd0;
          error_d   = bus.i_cmd_error;
          invalid_d = bus.i_cmd_invalid;
          state_d   = ARB_RESP;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output decode: master command mux, grant pulse and one-cycle response.
  always_comb begin
    bus.o_gnt          = '0;
    bus.o_resp_valid   = '0;
    bus.o_resp_rdata   = '0;
    bus.o_resp_error   = 1'b0;
    bus.o_resp_invalid = 1'b0;
    bus.o_busy         = (state_q != ARB_IDLE);
    bus.o_cmd_rw       = 2'b00;
    bus.o_cmd_size     = '0;
    bus.o_cmd_addr     = '0;
    bus.o_cmd_wdata    = '0;
    bus.o_cmd_clear    = 1'b1;
    if (state_q == ARB_ISSUE) begin
      bus.o_cmd_size  = grantSize;
      bus.o_cmd_addr  = grantAddr;
      bus.o_cmd_wdata = grantWdata;
      if (issueReserved) begin
        bus.o_gnt[grantIdx_q] = 1'b1;
      end else if (issueGo) begin
        bus.o_cmd_rw          = grantRw;
        bus.o_cmd_clear       = 1'b0;
        bus.o_gnt[grantIdx_q] = 1'b1;
      end
    end
    if (state_q == ARB_RESP) begin
      bus.o_resp_valid[grantIdx_q] = 1'b1;
      bus.o_resp_rdata             = rdata_q;
      bus.o_resp_error             = error_q;
      bus.o_resp_invalid           = invalid_q;
    end
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed self-checking bench for axi_master_arbiter. Inputs change just
// after the falling clock edge and outputs are sampled 1ns later.
module tb_axi_master_arbiter;

  localparam int NUM_REQ = 4;

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   checks = 0;
  int   errors = 0;

  axi_master_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  axi_master_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // Free-running 10ns clock.
  always #5 i_clk = ~i_clk;

  task automatic nextCycle();
    @(negedge i_clk);
  endtask

  task automatic clearInputs();
    bus.i_req         = '0;
    bus.i_req_rw      = '0;
    bus.i_req_size    = '0;
    bus.i_req_addr    = '0;
    bus.i_req_wdata   = '0;
    bus.i_cmd_wait    = 1'b0;
    bus.i_cmd_done    = 1'b0;
    bus.i_cmd_error   = 1'b0;
    bus.i_cmd_invalid = 1'b0;
    bus.i_cmd_rdata   = '0;
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] rw, input logic [2:0] size,
                               input logic [31:0] addr, input logic [63:0] wdata);
    bus.i_req[idx]                = 1'b1;
    bus.i_req_rw[2*idx +: 2]      = rw;
    bus.i_req_size[3*idx +: 3]    = size;
    bus.i_req_addr[32*idx +: 32]  = addr;
    bus.i_req_wdata[64*idx +: 64] = wdata;
  endtask

  task automatic dropReq(input int idx);
    bus.i_req[idx]           = 1'b0;
    bus.i_req_rw[2*idx +: 2] = 2'b00;
  endtask

  task automatic doReset();
    i_rst_n = 1'b0;
    clearInputs();
    repeat (2) nextCycle();
    i_rst_n = 1'b1;
    nextCycle();
  endtask

  task automatic test_reset();
    clearInputs();
    i_rst_n = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_cmd_clear !== 1'b1) begin errors++; $display("[TB] FAIL rst_clear: got %b want 1", bus.o_cmd_clear); end
    checks++; if (bus.o_cmd_rw !== 2'b00) begin errors++; $display("[TB] FAIL rst_cmd_rw: got %b want 00", bus.o_cmd_rw); end
    checks++; if (bus.o_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rst_gnt: got %b want 0000", bus.o_gnt); end
    checks++; if (bus.o_resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rst_resp_valid: got %b want 0000", bus.o_resp_valid); end
    repeat (2) nextCycle();
    i_rst_n = 1'b1;
    nextCycle();
    // A request with a zero command must be ignored.
    applyStimulus(0, 2'b00, 3'd2, 32'h10, 64'd0);
    nextCycle();
    nextCycle();
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rw00_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL rw00_gnt: got %b want 0000", bus.o_gnt); end
    dropReq(0);
    nextCycle();
  endtask

  task automatic test_single_read();
    applyStimulus(1, 2'b10, 3'd2, 32'h104, 64'd0);
    #1;
    checks++; if (bus.o_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL read_idle_gnt: got %b want 0000", bus.o_gnt); end
    nextCycle(); #1;
    checks++; if (bus.o_gnt !== 4'b0010) begin errors++; $display("[TB] FAIL read_gnt: got %b want 0010", bus.o_gnt); end
    checks++; if (bus.o_cmd_rw !== 2'b10) begin errors++; $display("[TB] FAIL read_cmd_rw: got %b want 10", bus.o_cmd_rw); end
    checks++; if (bus.o_cmd_addr !== 32'h104) begin errors++; $display("[TB] FAIL read_cmd_addr: got %h want 104", bus.o_cmd_addr); end
    checks++; if (bus.o_cmd_size !== 3'd2) begin errors++; $display("[TB] FAIL read_cmd_size: got %0d want 2", bus.o_cmd_size); end
    checks++; if (bus.o_cmd_clear !== 1'b0) begin errors++; $display("[TB] FAIL read_issue_clear: got %b want 0", bus.o_cmd_clear); end
    nextCycle();
    dropReq(1);
    bus.i_cmd_wait = 1'b1;
    #1;
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("[TB] FAIL read_wait_busy: got %b want 1", bus.o_busy); end
    checks++; if (bus.o_cmd_rw !== 2'b00) begin errors++; $display("[TB] FAIL read_wait_cmd_rw: got %b want 00", bus.o_cmd_rw); end
    repeat (4) nextCycle();
    bus.i_cmd_wait  = 1'b0;
    bus.i_cmd_done  = 1'b1;
    bus.i_cmd_rdata = 64'hDEADBEEF;
    #1;
    checks++; if (bus.o_cmd_clear !== 1'b1) begin errors++; $display("[TB] FAIL read_done_clear: got %b want 1", bus.o_cmd_clear); end
    checks++; if (bus.o_resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL read_early_resp: got %b want 0000", bus.o_resp_valid); end
    nextCycle();
    bus.i_cmd_done  = 1'b0;
    bus.i_cmd_rdata = 64'd0;
    #1;
    checks++; if (bus.o_resp_valid !== 4'b0010) begin errors++; $display("[TB] FAIL read_resp_valid: got %b want 0010", bus.o_resp_valid); end
    checks++; if (bus.o_resp_rdata !== 64'hDEADBEEF) begin errors++; $display("[TB] FAIL read_rdata: got %h want deadbeef", bus.o_resp_rdata); end
    checks++; if (bus.o_resp_error !== 1'b0) begin errors++; $display("[TB] FAIL read_error: got %b want 0", bus.o_resp_error); end
    nextCycle(); #1;
    checks++; if (bus.o_resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL read_resp_end: got %b want 0000", bus.o_resp_valid); end
    checks++; if (bus.o_resp_rdata !== 64'd0) begin errors++; $display("[TB] FAIL read_rdata_idle: got %h want 0", bus.o_resp_rdata); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL read_idle_busy: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_fairness();
    logic [3:0]  expGnt;
    logic [31:0] expAddr;
    doReset();
    for (int k = 0; k < NUM_REQ; k++) begin
      applyStimulus(k, 2'b01, 3'd2, 32'h1000 + 32'(k) * 32'h100, 64'(k) + 64'h50);
    end
    for (int t = 0; t < 6; t++) begin
      expGnt  = 4'b0001 << (t % 4);
      expAddr = 32'h1000 + 32'(t % 4) * 32'h100;
      #1;
      checks++; if (bus.o_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL fair_idle_gnt[%0d]: got %b want 0000", t, bus.o_gnt); end
      nextCycle(); #1;
      checks++; if (bus.o_gnt !== expGnt) begin errors++; $display("[TB] FAIL fair_gnt[%0d]: got %b want %b", t, bus.o_gnt, expGnt); end
      checks++; if (bus.o_cmd_addr !== expAddr) begin errors++; $display("[TB] FAIL fair_addr[%0d]: got %h want %h", t, bus.o_cmd_addr, expAddr); end
      nextCycle();
      bus.i_cmd_done = 1'b1;
      #1;
      checks++; if (bus.o_resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL fair_early_resp[%0d]: got %b want 0000", t, bus.o_resp_valid); end
      nextCycle();
      bus.i_cmd_done = 1'b0;
      #1;
      checks++; if (bus.o_resp_valid !== expGnt) begin errors++; $display("[TB] FAIL fair_resp[%0d]: got %b want %b", t, bus.o_resp_valid, expGnt); end
      checks++; if (bus.o_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL fair_resp_gnt[%0d]: got %b want 0000", t, bus.o_gnt); end
      nextCycle();
    end
    clearInputs();
    nextCycle();
  endtask

  task automatic test_misaligned();
    applyStimulus(2, 2'b01, 3'd3, 32'h1004, 64'hA5);
    nextCycle();
    bus.i_cmd_done    = 1'b1;
    bus.i_cmd_error   = 1'b1;
    bus.i_cmd_invalid = 1'b1;
    #1;
    checks++; if (bus.o_gnt !== 4'b0100) begin errors++; $display("[TB] FAIL mis_gnt: got %b want 0100", bus.o_gnt); end
    checks++; if (bus.o_cmd_rw !== 2'b01) begin errors++; $display("[TB] FAIL mis_cmd_rw: got %b want 01", bus.o_cmd_rw); end
    nextCycle();
    clearInputs();
    #1;
    checks++; if (bus.o_resp_valid !== 4'b0100) begin errors++; $display("[TB] FAIL mis_resp: got %b want 0100", bus.o_resp_valid); end
    checks++; if (bus.o_resp_error !== 1'b1) begin errors++; $display("[TB] FAIL mis_error: got %b want 1", bus.o_resp_error); end
    checks++; if (bus.o_resp_invalid !== 1'b1) begin errors++; $display("[TB] FAIL mis_invalid: got %b want 1", bus.o_resp_invalid); end
    checks++; if (bus.o_resp_rdata !== 64'd0) begin errors++; $display("[TB] FAIL mis_rdata: got %h want 0", bus.o_resp_rdata); end
    nextCycle(); #1;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL mis_idle_busy: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_reserved();
    applyStimulus(3, 2'b11, 3'd2, 32'h200, 64'd7);
    #1;
    checks++; if (bus.o_cmd_rw !== 2'b00) begin errors++; $display("[TB] FAIL rsv_idle_rw: got %b want 00", bus.o_cmd_rw); end
    nextCycle(); #1;
    checks++; if (bus.o_gnt !== 4'b1000) begin errors++; $display("[TB] FAIL rsv_gnt: got %b want 1000", bus.o_gnt); end
    checks++; if (bus.o_cmd_rw !== 2'b00) begin errors++; $display("[TB] FAIL rsv_issue_rw: got %b want 00", bus.o_cmd_rw); end
    nextCycle();
    dropReq(3);
    #1;
    checks++; if (bus.o_resp_valid !== 4'b1000) begin errors++; $display("[TB] FAIL rsv_resp: got %b want 1000", bus.o_resp_valid); end
    checks++; if (bus.o_resp_error !== 1'b1) begin errors++; $display("[TB] FAIL rsv_error: got %b want 1", bus.o_resp_error); end
    checks++; if (bus.o_resp_invalid !== 1'b1) begin errors++; $display("[TB] FAIL rsv_invalid: got %b want 1", bus.o_resp_invalid); end
    checks++; if (bus.o_resp_rdata !== 64'd0) begin errors++; $display("[TB] FAIL rsv_rdata: got %h want 0", bus.o_resp_rdata); end
    checks++; if (bus.o_cmd_rw !== 2'b00) begin errors++; $display("[TB] FAIL rsv_resp_rw: got %b want 00", bus.o_cmd_rw); end
    nextCycle();
  endtask

  task automatic test_slave_error();
    applyStimulus(0, 2'b01, 3'd2, 32'h300, 64'h1122);
    nextCycle(); #1;
    checks++; if (bus.o_gnt !== 4'b0001) begin errors++; $display("[TB] FAIL serr_gnt: got %b want 0001", bus.o_gnt); end
    nextCycle();
    dropReq(0);
    bus.i_cmd_done  = 1'b1;
    bus.i_cmd_error = 1'b1;
    bus.i_cmd_rdata = 64'hFFFF;
    nextCycle();
    bus.i_cmd_done  = 1'b0;
    bus.i_cmd_error = 1'b0;
    bus.i_cmd_rdata = 64'd0;
    applyStimulus(1, 2'b10, 3'd2, 32'h400, 64'd0);
    #1;
    checks++; if (bus.o_resp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL serr_resp: got %b want 0001", bus.o_resp_valid); end
    checks++; if (bus.o_resp_error !== 1'b1) begin errors++; $display("[TB] FAIL serr_error: got %b want 1", bus.o_resp_error); end
    checks++; if (bus.o_resp_invalid !== 1'b0) begin errors++; $display("[TB] FAIL serr_invalid: got %b want 0", bus.o_resp_invalid); end
    checks++; if (bus.o_resp_rdata !== 64'd0) begin errors++; $display("[TB] FAIL serr_write_rdata: got %h want 0", bus.o_resp_rdata); end
    checks++; if (bus.o_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL serr_resp_gnt: got %b want 0000", bus.o_gnt); end
    nextCycle(); #1;
    checks++; if (bus.o_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL next_idle_gnt: got %b want 0000", bus.o_gnt); end
    nextCycle();
    bus.i_cmd_wait = 1'b1;
    #1;
    checks++; if (bus.o_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL next_stall_gnt: got %b want 0000", bus.o_gnt); end
    checks++; if (bus.o_cmd_rw !== 2'b00) begin errors++; $display("[TB] FAIL next_stall_rw: got %b want 00", bus.o_cmd_rw); end
    nextCycle();
    bus.i_cmd_wait = 1'b0;
    #1;
    checks++; if (bus.o_gnt !== 4'b0010) begin errors++; $display("[TB] FAIL next_gnt: got %b want 0010", bus.o_gnt); end
    checks++; if (bus.o_cmd_rw !== 2'b10) begin errors++; $display("[TB] FAIL next_cmd_rw: got %b want 10", bus.o_cmd_rw); end
    nextCycle();
    dropReq(1);
    bus.i_cmd_done  = 1'b1;
    bus.i_cmd_rdata = 64'h55;
    nextCycle();
    bus.i_cmd_done  = 1'b0;
    bus.i_cmd_rdata = 64'd0;
    #1;
    checks++; if (bus.o_resp_valid !== 4'b0010) begin errors++; $display("[TB] FAIL next_resp: got %b want 0010", bus.o_resp_valid); end
    checks++; if (bus.o_resp_rdata !== 64'h55) begin errors++; $display("[TB] FAIL next_rdata: got %h want 55", bus.o_resp_rdata); end
    nextCycle();
  endtask

  task automatic test_reset_mid_wait();
    applyStimulus(2, 2'b10, 3'd2, 32'h500, 64'd0);
    nextCycle(); #1;
    checks++; if (bus.o_gnt !== 4'b0100) begin errors++; $display("[TB] FAIL rmw_gnt: got %b want 0100", bus.o_gnt); end
    nextCycle();
    dropReq(2);
    bus.i_cmd_wait = 1'b1;
    #1;
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("[TB] FAIL rmw_wait_busy: got %b want 1", bus.o_busy); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL rmw_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_cmd_clear !== 1'b1) begin errors++; $display("[TB] FAIL rmw_clear: got %b want 1", bus.o_cmd_clear); end
    checks++; if (bus.o_cmd_addr !== 32'd0) begin errors++; $display("[TB] FAIL rmw_addr: got %h want 0", bus.o_cmd_addr); end
    nextCycle();
    bus.i_cmd_wait = 1'b0;
    nextCycle();
    i_rst_n = 1'b1;
    applyStimulus(1, 2'b01, 3'd2, 32'h600, 64'd1);
    applyStimulus(3, 2'b01, 3'd2, 32'h700, 64'd3);
    #1;
    checks++; if (bus.o_resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rmw_no_resp: got %b want 0000", bus.o_resp_valid); end
    nextCycle(); #1;
    checks++; if (bus.o_gnt !== 4'b0010) begin errors++; $display("[TB] FAIL rmw_first_gnt: got %b want 0010", bus.o_gnt); end
    checks++; if (bus.o_resp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rmw_no_resp2: got %b want 0000", bus.o_resp_valid); end
    clearInputs();
    nextCycle();
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_misaligned();
    test_reserved();
    test_slave_error();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
